// File: rtl/bch_pkg.sv
// Shared GF(2^M) helpers for the BCH decoder: field polynomials, multiply, alpha powers.
package bch_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } chien_state_e;

  // Primitive polynomial (including the x^M term) for each supported field width.
  function automatic logic [16:0] field_poly(input int m);
    case (m)
      4:       return 17'h00013;
      5:       return 17'h00025;
      6:       return 17'h00043;
      7:       return 17'h00089;
      8:       return 17'h0011D;
      9:       return 17'h00211;
      10:      return 17'h00409;
      11:      return 17'h00805;
      12:      return 17'h01053;
      13:      return 17'h0201B;
      14:      return 17'h04443;
      15:      return 17'h08003;
      16:      return 17'h1100B;
      default: return 17'h0011D;
    endcase
  endfunction

  function automatic logic [15:0] gf_mul(input logic [15:0] a, input logic [15:0] b,
                                         input int m);
    logic [16:0] aa;
    logic [16:0] poly;
    logic [15:0] res;
    poly = field_poly(m);
    aa   = {1'b0, a};
    res  = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < m) begin
        if (b[i]) res = res ^ aa[15:0];
        aa = aa << 1;
        if (aa[m]) aa = aa ^ poly;
      end
    end
    return res;
  endfunction

  // alpha^k by square-and-multiply; k is reduced modulo 2^m-1 first.
  function automatic logic [15:0] gf_pow(input int k, input int m);
    int          n;
    int          e;
    logic [15:0] res;
    logic [15:0] base;
    n = (1 << m) - 1;
    e = k % n;
    if (e < 0) e = e + n;
    res  = 16'd1;
    base = 16'd2;
    for (int i = 0; i < 16; i++) begin
      if (e[i]) res = gf_mul(res, base, m);
      base = gf_mul(base, base, m);
    end
    return res;
  endfunction

endpackage

// File: rtl/bch_chien_term.sv
// One Chien term register: loads coef*alpha^LOAD_EXP, then multiplies by alpha^STEP_EXP per advance.
module bch_chien_term
  import bch_pkg::*;
#(
  parameter int M        = 8,
  parameter int LOAD_EXP = 0,
  parameter int STEP_EXP = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic         advance_i,
  input  logic [M-1:0] coef_i,
  output logic [M-1:0] term_o
);

  localparam logic [15:0] LOAD_C = gf_pow(LOAD_EXP, M);
  localparam logic [15:0] STEP_C = gf_pow(STEP_EXP, M);

  logic [M-1:0] term_q, term_d;
  logic [15:0]  load_prod, step_prod;

  // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    load_prod = gf_mul(16'(coef_i), LOAD_C, M);
    step_prod = gf_mul(16'(term_q), STEP_C, M);
    term_d    = term_q;
    if (load_i)         term_d = load_prod[M-1:0];
    else if (advance_i) term_d = step_prod[M-1:0];
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) term_q <= '0;
    else          term_q <= term_d;
  end

  assign term_o = term_q;

endmodule

// File: rtl/bch_chien_search.sv
// Chien search over DATA_BITS positions, BITS per beat, with valid/ready on both sides.
// Define BCH_CHIEN_FAIL_CHECK_EN to compare the root count against deg(sigma) for the fail flag.
module bch_chien_search
  import bch_pkg::*;
#(
  parameter int M         = 8,
  parameter int T         = 4,
  parameter int DATA_BITS = 223,
  parameter int BITS      = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [(T+1)*M-1:0]     sigma,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BITS-1:0]        err_mask,
  output logic                   out_first,
  output logic                   out_last,
  output logic [$clog2(T+2)-1:0] err_count,
  output logic                   fail
);

  localparam int N          = (1 << M) - 1;
  localparam int SKIP       = N - M * T - DATA_BITS;
  localparam int CYCLES     = (DATA_BITS + BITS - 1) / BITS;
  localparam int LAST_VALID = DATA_BITS - (CYCLES - 1) * BITS;
  localparam int CW         = $clog2(T + 2);

  chien_state_e state_q, state_d;
  logic [M-1:0]  beat_q, beat_d;
  logic [CW-1:0] count_q, count_d;
  logic          run, accept, xfer;
  logic [M-1:0]  term_w [T+1][BITS];
  logic [M-1:0]  eval_acc;
  logic [BITS-1:0] root;
  int            hits;
  int            sum;

  assign run       = (state_q == ST_RUN);
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = run;
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign out_first = run && (beat_q == '0);
  assign out_last  = run && (beat_q == M'(CYCLES - 1));

  for (genvar i = 0; i <= T; i++) begin : g_coef
    for (genvar b = 0; b < BITS; b++) begin : g_bit
      bch_chien_term #(
        .M       (M),
        .LOAD_EXP(i * (1 + SKIP + b)),
        .STEP_EXP(i * BITS)
      ) u_term (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (accept),
        .advance_i(xfer),
        .coef_i   (sigma[i*M +: M]),
        .term_o   (term_w[i][b])
      );
    end
  end

  // Positions past DATA_BITS in the final beat are padding and never flagged.
  always_comb begin
    root     = '0;
    eval_acc = '0;
    for (int b = 0; b < BITS; b++) begin
      eval_acc = '0;
      for (int i = 0; i <= T; i++) eval_acc = eval_acc ^ term_w[i][b];
      root[b] = (eval_acc == '0) && (!out_last || (b < LAST_VALID));
    end
    err_mask = run ? root : '0;
    hits = 0;
    for (int b = 0; b < BITS; b++) hits = hits + int'(err_mask[b]);
    sum       = int'(count_q) + hits;
    err_count = (sum > T + 1) ? CW'(T + 1) : CW'(sum);
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          beat_d  = '0;
          count_d = '0;
        end
      end
      ST_RUN: begin
        if (out_ready) begin
          count_d = err_count;
          if (beat_q == M'(CYCLES - 1)) state_d = ST_IDLE;
          else                          beat_d  = beat_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      count_q <= count_d;
    end
  end

`ifdef BCH_CHIEN_FAIL_CHECK_EN
  logic [CW-1:0] deg_q, deg_d;
  logic          s0_zero_q;

  always_comb begin
    deg_d = '0;
    for (int i = 1; i <= T; i++) begin
      if (sigma[i*M +: M] != '0) deg_d = CW'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deg_q     <= '0;
      s0_zero_q <= 1'b0;
    end else if (accept) begin
      deg_q     <= deg_d;
      s0_zero_q <= (sigma[M-1:0] == '0);
    end
  end

  assign fail = run && ((err_count != deg_q) || s0_zero_q);
`else
  assign fail = 1'b0;
`endif

endmodule

// File: doc/bch_chien_search.md
BCH_CHIEN_SEARCH -- requirements
Module: bch_chien_search

Interface
REQ-001 Parameter M, default 8: field width; GF(2^M) with N = 2^M-1; legal range 4..16.
REQ-002 Parameter T, default 4: correctable errors; sigma has T+1 coefficients.
REQ-003 Parameter DATA_BITS, default 223: data bits searched; SKIP = N - M*T - DATA_BITS; SKIP SHALL be >= 0.
REQ-004 Parameter BITS, default 1: positions evaluated per beat, 1..8; CYCLES = ceil(DATA_BITS/BITS).
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  sigma offered.
REQ-008 in_ready  out  1  block idle, sigma accepted on in_valid&&in_ready.
REQ-009 sigma  in  (T+1)*M  error locator; coefficient i at [i*M +: M].
REQ-010 out_valid  out  1  err_mask beat valid.
REQ-011 out_ready  in  1  downstream accepts beat.
REQ-012 err_mask  out  BITS  bit b set = data position k*BITS+b in error (beat k, transmission order).
REQ-013 out_first / out_last  out  1 each  marks beat 0 / beat CYCLES-1.
REQ-014 err_count  out  $clog2(T+2)  cumulative roots incl. current beat, saturating at T+1.
REQ-015 fail  out  1  decode failure; meaningful only with out_last.

Function
REQ-016 Position p is in error iff sum over i of sigma_i*alpha^(i*(1+SKIP+p)) = 0 (GF(2^M), field polynomial from package).
REQ-017 On accept, term register (i,b) SHALL load sigma_i*alpha^(i*(1+SKIP+b)); each beat advance it multiplies by alpha^(i*BITS).
REQ-018 States IDLE -> RUN on accept; RUN -> IDLE when beat CYCLES-1 is transferred (out_valid&&out_ready).
REQ-019 in_ready SHALL be 1 only in IDLE; in_valid in RUN is ignored; no back-to-back accept on the cycle of final transfer.
REQ-020 Latency: out_valid rises the cycle after accept; one beat per cycle when out_ready stays 1.
REQ-021 out_valid&&!out_ready SHALL hold err_mask, flags, count and all term registers unchanged.
REQ-022 Final-beat positions >= DATA_BITS SHALL read 0 in err_mask and not count.
REQ-023 CYCLES=1: out_first and out_last SHALL both assert on the single beat.
REQ-024 Beat counter SHALL be an M-bit-or-wider binary counter clearing on accept.

Reset
REQ-025 reset_n low SHALL force IDLE, in_ready=1, out_valid=0, out_first=0, out_last=0, err_mask=0, err_count=0, fail=0, term registers 0.
REQ-026 Reset asserted mid-RUN SHALL abort the search with no further beats; first accept after release restarts cleanly.

Configuration
REQ-027 Macro BCH_CHIEN_FAIL_CHECK_EN defined: fail = (err_count != deg(sigma)) || sigma_0==0, deg = highest nonzero index, latched at accept.
REQ-028 Macro undefined: fail tied 0, degree logic absent; all other behaviour identical.

Structure
REQ-029 Shared package bch_pkg SHALL hold field-polynomial table per M, gf_mul and gf_pow (alpha^k) constant functions.
REQ-030 Sub-module bch_chien_term: one term register with load/advance/hold and constant multipliers; instantiated (T+1)*BITS times.

Verification
REQ-031 sigma=1 (others 0), defaults -> CYCLES=223 beats, all err_mask 0, err_count 0, fail 0.
REQ-032 sigma_0=1, sigma_1=alpha^-(1+SKIP+5) -> only beat 5 err_mask=1, final err_count 1, fail 0.
REQ-033 BITS=4, errors at p=0 and p=222 -> beat 0 mask 4'b0001, beat 55 mask 4'b0100, bit 3 of beat 55 0, err_count 2.
REQ-034 Random out_ready throttling (~50%) on REQ-032 -> mask stream identical to unthrottled run, no beat lost or duplicated.
REQ-035 reset_n pulsed low at beat 100 -> out_valid 0 within same cycle, in_ready 1; next search matches golden model.
REQ-036 Fail-check build, sigma of degree 2 with roots outside data range -> err_count 0, fail 1 with out_last.
